// File: rtl/mem_access_sequencer.sv
// External-memory transaction sequencer: SETUP / ACCESS (with wait states) / HOLD per request.
// Optional `MEMSEQ_ACCESS_COUNT_EN adds a saturating completed-transaction counter with clear.
module mem_access_sequencer #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [ADDR_W-1:0] MEMADDR,
    output logic [7:0]        MEMDATA_out,
    output logic              MEM_OE_n,
    output logic              MEM_WE_n,
    input  logic [7:0]        MEMDATA_in,
`ifdef MEMSEQ_ACCESS_COUNT_EN
    input  logic              access_count_clr,
    output logic [15:0]       access_count,
`endif
    output logic              MemBridge_Assert,
    output logic              MemBridge_Direction
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e            state_q;
    logic [3:0]        wait_cnt_q;
    logic              write_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_oe_n_q;
    logic              mem_we_n_q;
    logic              bridge_assert_q;

    // Every output is computed on the edge that enters the state it belongs to,
    // so the strobes and bridge controls come straight from flops.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= 4'd0;
            write_q         <= 1'b0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= 8'h00;
            mem_addr_q      <= '0;
            mem_wdata_q     <= 8'h00;
            mem_oe_n_q      <= 1'b1;
            mem_we_n_q      <= 1'b1;
            bridge_assert_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_q         <= req_write;
                        mem_addr_q      <= req_addr;
                        mem_wdata_q     <= req_wdata;
                        bridge_assert_q <= req_write;
                        req_ready_q     <= 1'b0;
                        state_q         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wait_cnt_q      <= WAIT_INIT;
                    bridge_assert_q <= 1'b1;
                    mem_oe_n_q      <= write_q;
                    mem_we_n_q      <= !write_q;
                    state_q         <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wait_cnt_q == 4'd0) begin
                        if (!write_q) begin
                            rsp_rdata_q <= MEMDATA_in;
                        end
                        mem_oe_n_q      <= 1'b1;
                        mem_we_n_q      <= 1'b1;
                        // A read keeps the bridge on in HOLD to present the captured byte.
                        bridge_assert_q <= !write_q;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= ST_HOLD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    rsp_valid_q     <= 1'b0;
                    bridge_assert_q <= 1'b0;
                    req_ready_q     <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign MEMADDR             = mem_addr_q;
    assign MEMDATA_out         = mem_wdata_q;
    assign MEM_OE_n            = mem_oe_n_q;
    assign MEM_WE_n            = mem_we_n_q;
    assign MemBridge_Assert    = bridge_assert_q;
    assign MemBridge_Direction = write_q;

`ifdef MEMSEQ_ACCESS_COUNT_EN
    logic [15:0] access_count_q;
    logic [15:0] access_count_d;

    // Clear wins over a same-cycle completion; the count sticks at all-ones.
    always_comb begin
        access_count_d = access_count_q;
        if (access_count_clr) begin
            access_count_d = 16'h0000;
        end else if (rsp_valid_q && (access_count_q != 16'hFFFF)) begin
            access_count_d = access_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            access_count_q <= 16'h0000;
        end else begin
            access_count_q <= access_count_d;
        end
    end

    assign access_count = access_count_q;
`endif

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Sequences one external-memory transaction per request for the pipelined CPU. It sits directly upstream of the memory bus bridge, and it alone drives MemBridge_Assert and MemBridge_Direction. It also generates the address, chip strobes and write data for memory, inserts a configurable number of wait states, and returns captured read data to the pipeline over a valid/ready handshake.

Parameters:
WAIT_STATES, 2, extra ACCESS cycles beyond the first; legal range 0..15.
ADDR_W, 16, memory address width.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RESET  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  target address.
req_wdata  in  8  write data.
rsp_valid  out  1  one-cycle pulse: transaction complete.
rsp_rdata  out  8  read data; holds its value until the next read completes.
MEMADDR  out  ADDR_W  address to memory.
MEMDATA_out  out  8  data driven toward the bridge/memory on writes.
MEM_OE_n  out  1  memory output enable, active low.
MEM_WE_n  out  1  memory write enable, active low.
MEMDATA_in  in  8  data returned from memory.
MemBridge_Assert  out  1  enables the bridge drivers.
MemBridge_Direction  out  1  1 = MainBus to MEMDATA (write); 0 = MEMDATA to MainBus (read).

Behaviour:
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0x00; MEMADDR 0; MEMDATA_out 0x00; MEM_OE_n 1; MEM_WE_n 1; MemBridge_Assert 0; MemBridge_Direction 0.
- Reset applies at the next edge, including mid-transaction. The transaction is abandoned: no rsp_valid pulse, and all strobes are deasserted on that edge.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch addr, wdata and write into registers; go to SETUP.
- SETUP (1 cycle):
  - MEMADDR valid; MemBridge_Direction = latched write.
  - Write: MemBridge_Assert=1 and MEMDATA_out driven.
  - Read: MemBridge_Assert=0.
  - Both strobes remain high.
- ACCESS (WAIT_STATES+1 cycles, counted by a 4-bit down-counter loaded with WAIT_STATES):
  - Read: MEM_OE_n=0.
  - Write: MEM_WE_n=0.
  - MemBridge_Assert=1.
  - On the final ACCESS cycle (counter==0), a read registers MEMDATA_in into rsp_rdata. Go to HOLD.
- HOLD (1 cycle):
  - MEM_WE_n=1 and MEM_OE_n=1.
  - Address, direction and MEMDATA_out are still held (provides write hold time).
  - MemBridge_Assert=1 for a read (the captured byte is presented toward MainBus); 0 for a write.
  - rsp_valid=1 for exactly this cycle. Next state is IDLE.
- req_ready is 0 in SETUP, ACCESS and HOLD. A request arriving during these states waits; it is not lost or queued.
- Latency: acceptance edge t0, then SETUP at t0+1, ACCESS at t0+2..t0+2+WAIT_STATES, and HOLD/rsp_valid at t0+3+WAIT_STATES. Back-to-back throughput is one transaction per WAIT_STATES+4 cycles.
- MEM_OE_n and MEM_WE_n are never low in the same cycle.
- MemBridge_Direction never changes while MemBridge_Assert=1.
- All outputs are registered.
- rsp_rdata is unchanged by writes.

Optional Feature:
MEMSEQ_ACCESS_COUNT_EN
- Defined: adds output access_count[15:0], reset to 0, which increments on every rsp_valid and saturates at 0xFFFF. Adds input access_count_clr, which zeroes the counter synchronously and takes priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
1. Read, WAIT_STATES=2: MEMDATA_in=0xA5 held, req addr 0x1234 accepted at t0 -> MEM_OE_n low t0+2..t0+4; rsp_valid only at t0+5; rsp_rdata=0xA5; MemBridge_Direction=0 throughout.
2. Write 0x3C to 0x8001 -> MEM_WE_n low for exactly 3 cycles; MEMDATA_out=0x3C and MEMADDR=0x8001 from SETUP through HOLD; MemBridge_Direction=1; rsp_rdata unchanged.
3. Back-to-back, req_valid held high with read then write -> second acceptance exactly 6 cycles after the first; req_ready 0 in between; no strobe overlap.
4. WAIT_STATES=0 -> ACCESS lasts 1 cycle; rsp_valid at t0+3.
5. RESET asserted during the second ACCESS cycle of a write -> next edge: IDLE, MEM_WE_n=1, MemBridge_Assert=0, no rsp_valid; next request proceeds normally.
6. With MEMSEQ_ACCESS_COUNT_EN defined: 3 transactions -> access_count=3; access_count_clr asserted together with a completing rsp_valid -> count=0.
